// File: rtl/s2p_pkg.sv
// Shared types and defaults for the s2p_rx serial-to-parallel receiver.
// The optional parity stage is enabled by defining S2P_PARITY_EN.
package s2p_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } state_e;

   // A len field of 0 selects a full DATA_W-bit word.
   function automatic logic [CNT_W_DEF:0] eff_len(input logic [CNT_W_DEF-1:0] len);
      return (len == '0) ? (CNT_W_DEF+1)'(DATA_W_DEF) : {1'b0, len};
   endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Output holding register for s2p_rx: valid/ready handshake and sticky overrun.
// A new word is dropped when the held word is unconsumed and not accepted this edge.
module s2p_out_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] word_in,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              overrun
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic              blocked;

   always_comb begin
      blocked = valid_q & ~out_ready;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (valid_q && out_ready) valid_d = 1'b0;
      if (load) begin
         if (blocked) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = word_in;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign overrun   = ovr_q;

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: MSB-first capture of 1..16 bits, MSB-aligned output.
// Define S2P_PARITY_EN to add a trailing parity bit and the parity_err output.
//
// state    | meaning
// ST_IDLE  | no word in progress; enable=1 captures the first bit
// ST_SHIFT | capturing data bits until count reaches len_q
// ST_PAR   | capturing the parity bit (S2P_PARITY_EN only)
module s2p_rx
   import s2p_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
`ifdef S2P_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_in,
   input  logic              enable,
   input  logic [CNT_W-1:0]  len,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              overrun
`ifdef S2P_PARITY_EN
   , output logic            parity_err
`endif
);

   state_e            state_q, state_d;
   logic [CNT_W:0]    count_q, count_d;
   logic [CNT_W:0]    len_q, len_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] word;
   logic [CNT_W-1:0]  idx;
   logic              done;
`ifdef S2P_PARITY_EN
   logic              par_calc;
   logic              accept;
   logic              perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      shift_d = shift_q;
      done    = 1'b0;
      idx     = CNT_W'(DATA_W-1) - count_q[CNT_W-1:0];
`ifdef S2P_PARITY_EN
      par_calc = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               shift_d             = '0;
               shift_d[DATA_W-1]   = data_in;
               len_d               = eff_len(len);
               count_d             = (CNT_W+1)'(1);
               state_d             = ST_SHIFT;
               if (len_d == (CNT_W+1)'(1)) begin
                  count_d = '0;
`ifdef S2P_PARITY_EN
                  state_d = ST_PAR;
`else
                  done    = 1'b1;
                  state_d = ST_IDLE;
`endif
               end
            end
         end
         ST_SHIFT: begin
            if (!enable) begin
               state_d = ST_IDLE;
               count_d = '0;
               shift_d = '0;
            end else begin
               shift_d[idx] = data_in;
               count_d      = count_q + 1'b1;
               if (count_d == len_q) begin
                  count_d = '0;
`ifdef S2P_PARITY_EN
                  state_d = ST_PAR;
`else
                  done    = 1'b1;
                  state_d = ST_IDLE;
`endif
               end
            end
         end
`ifdef S2P_PARITY_EN
         ST_PAR: begin
            state_d = ST_IDLE;
            if (!enable) begin
               shift_d = '0;
            end else begin
               done     = 1'b1;
               par_calc = ((^shift_q) ^ data_in) != PARITY_ODD;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
            shift_d = '0;
         end
      endcase
      // Mask is taken from the word being completed, before the shifter is cleared.
      word = shift_d & ~({DATA_W{1'b1}} >> len_d);
      if (done) shift_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         len_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         shift_q <= shift_d;
      end
   end

   assign busy = (state_q != ST_IDLE);

   s2p_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (done),
      .word_in   (word),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

`ifdef S2P_PARITY_EN
   always_comb begin
      accept = done & ~(out_valid & ~out_ready);
      perr_d = accept ? par_calc : perr_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) perr_q <= 1'b0;
      else        perr_q <= perr_d;
   end

   assign parity_err = perr_q;
`endif

endmodule
